// File: rtl/serdesphy_async_fifo_p.sv
// ============================================================================
//  Module      : serdesphy_async_fifo_p
//  Description : Dual-clock FWFT FIFO for the RX path, Gray-pointer CDC,
//                per-domain levels, almost-full/empty, sticky ovf/unf flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module serdesphy_async_fifo_p #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 3,
    parameter int AFULL_TH    = 6,
    parameter int AEMPTY_TH   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              wr_clk,
    input  logic              wr_rst_n,
    input  logic              rd_clk,
    input  logic              rd_rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_full,
    output logic              wr_afull,
    output logic [ADDR_W:0]   wr_level,
    output logic              wr_ovf,
    input  logic              wr_ovf_clr,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_aempty,
    output logic [ADDR_W:0]   rd_level,
    output logic              rd_unf,
    input  logic              rd_unf_clr
);

    localparam int              c_depth     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] c_afull_th  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] c_aempty_th = (ADDR_W+1)'(AEMPTY_TH);
    localparam logic [ADDR_W:0] c_one       = (ADDR_W+1)'(1);

    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DATA_W-1:0] r_mem [c_depth];

    logic [ADDR_W:0]                   r_wr_bin, r_wr_gray, w_wr_bin_nxt, w_rq_bin;
    logic [ADDR_W:0]                   r_rd_bin, r_rd_gray, w_rd_bin_nxt, w_wq_bin;
    logic [SYNC_STAGES-1:0][ADDR_W:0]  r_rq_sync;
    logic [SYNC_STAGES-1:0][ADDR_W:0]  r_wq_sync;
    logic                              r_wr_ovf, r_rd_unf;
    logic                              w_wr_push, w_rd_pop;

    // ---------------- write domain ----------------
    assign w_wr_push    = wr_en && !wr_full;
    assign w_wr_bin_nxt = r_wr_bin + c_one;

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            r_wr_bin  <= '0;
            r_wr_gray <= '0;
            r_rq_sync <= '0;
            r_wr_ovf  <= 1'b0;
        end else begin
            r_rq_sync <= {r_rq_sync[SYNC_STAGES-2:0], r_rd_gray};
            if (w_wr_push) begin
                r_wr_bin  <= w_wr_bin_nxt;
                r_wr_gray <= w_wr_bin_nxt ^ (w_wr_bin_nxt >> 1);
            end
            // A new overflow in the same cycle as a clear keeps the flag set.
            if (wr_en && wr_full)
                r_wr_ovf <= 1'b1;
            else if (wr_ovf_clr)
                r_wr_ovf <= 1'b0;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (w_wr_push)
            r_mem[r_wr_bin[ADDR_W-1:0]] <= wr_data;
    end

    assign w_rq_bin = gray2bin(r_rq_sync[SYNC_STAGES-1]);
    assign wr_full  = (r_wr_gray == {~r_rq_sync[SYNC_STAGES-1][ADDR_W -: 2],
                                      r_rq_sync[SYNC_STAGES-1][ADDR_W-2:0]});
    assign wr_level = r_wr_bin - w_rq_bin;
    assign wr_afull = (wr_level >= c_afull_th);
    assign wr_ovf   = r_wr_ovf;

    // ---------------- read domain ----------------
    assign w_rd_pop     = rd_en && rd_valid;
    assign w_rd_bin_nxt = r_rd_bin + c_one;

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            r_rd_bin  <= '0;
            r_rd_gray <= '0;
            r_wq_sync <= '0;
            r_rd_unf  <= 1'b0;
        end else begin
            r_wq_sync <= {r_wq_sync[SYNC_STAGES-2:0], r_wr_gray};
            if (w_rd_pop) begin
                r_rd_bin  <= w_rd_bin_nxt;
                r_rd_gray <= w_rd_bin_nxt ^ (w_rd_bin_nxt >> 1);
            end
            if (rd_en && !rd_valid)
                r_rd_unf <= 1'b1;
            else if (rd_unf_clr)
                r_rd_unf <= 1'b0;
        end
    end

    assign w_wq_bin  = gray2bin(r_wq_sync[SYNC_STAGES-1]);
    assign rd_valid  = (r_rd_gray != r_wq_sync[SYNC_STAGES-1]);
    assign rd_data   = r_mem[r_rd_bin[ADDR_W-1:0]];
    assign rd_level  = w_wq_bin - r_rd_bin;
    assign rd_aempty = (rd_level <= c_aempty_th);
    assign rd_unf    = r_rd_unf;

endmodule

`default_nettype wire

// File: tb/tb_serdesphy_async_fifo_p.sv
// ============================================================================
//  Module      : tb_serdesphy_async_fifo_p
//  Description : Directed and randomised checks of the dual-clock RX FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_serdesphy_async_fifo_p;

    logic       wr_clk, rd_clk, wr_rst_n, rd_rst_n;
    logic       wr_en, wr_ovf_clr, rd_en, rd_unf_clr;
    logic [7:0] wr_data, rd_data;
    logic [3:0] wr_level, rd_level;
    logic       wr_full, wr_afull, wr_ovf, rd_valid, rd_aempty, rd_unf;

    int tests = 0;
    int fails = 0;

    localparam logic [13:0] c_rst_vec = {1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0};

    serdesphy_async_fifo_p #(
        .DATA_W(8), .ADDR_W(3), .AFULL_TH(6), .AEMPTY_TH(2), .SYNC_STAGES(2)
    ) dut (
        .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .rd_clk(rd_clk), .rd_rst_n(rd_rst_n),
        .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full), .wr_afull(wr_afull),
        .wr_level(wr_level), .wr_ovf(wr_ovf), .wr_ovf_clr(wr_ovf_clr),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .rd_aempty(rd_aempty),
        .rd_level(rd_level), .rd_unf(rd_unf), .rd_unf_clr(rd_unf_clr)
    );

    // 24 MHz write clock; read clock ~200 ppm slower with a phase offset.
    initial begin
        wr_clk = 1'b0;
        forever #20.833 wr_clk = ~wr_clk;
    end
    initial begin
        rd_clk = 1'b0;
        #7;
        forever #20.837 rd_clk = ~rd_clk;
    end

    task automatic wr_tick;
        @(posedge wr_clk);
        #1;
    endtask

    task automatic rd_tick;
        @(posedge rd_clk);
        #1;
    endtask

    function automatic logic [13:0] status_vec();
        return {wr_full, wr_afull, wr_level, wr_ovf, rd_valid, rd_aempty, rd_level, rd_unf};
    endfunction

    task automatic test_reset;
        wr_rst_n = 1'b0; rd_rst_n = 1'b0;
        wr_en = 1'b0; wr_data = '0; wr_ovf_clr = 1'b0; rd_en = 1'b0; rd_unf_clr = 1'b0;
        #100;
        @(posedge wr_clk);
        #1;
        wr_rst_n = 1'b1; rd_rst_n = 1'b1;
        #1;
        tests++;
        if (status_vec() !== c_rst_vec) begin
            fails++;
            $display("FAIL reset_state: got %b expected %b", status_vec(), c_rst_vec);
        end
    endtask

    task automatic test_single_word;
        logic found = 1'b0;
        wr_data = 8'hA5; wr_en = 1'b1;
        wr_tick();
        wr_en = 1'b0;
        for (int i = 0; i < 3 && !found; i++) begin
            rd_tick();
            if (rd_valid === 1'b1) found = 1'b1;
        end
        tests++;
        if (found !== 1'b1) begin
            fails++;
            $display("FAIL single_latency: rd_valid got %b expected 1 within 3 rd edges", rd_valid);
        end
        tests++;
        if (rd_data !== 8'hA5) begin
            fails++;
            $display("FAIL single_data: got %h expected a5", rd_data);
        end
        tests++;
        if (rd_level !== 4'd1) begin
            fails++;
            $display("FAIL single_level: got %0d expected 1", rd_level);
        end
        rd_en = 1'b1;
        rd_tick();
        rd_en = 1'b0;
        tests++;
        if (rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_pop: rd_valid got %b expected 0", rd_valid);
        end
        repeat (6) wr_tick();
    endtask

    task automatic test_overflow;
        for (int n = 1; n <= 9; n++) begin
            wr_data = n[7:0]; wr_en = 1'b1;
            wr_tick();
            tests++;
            if (wr_afull !== (n >= 6)) begin
                fails++;
                $display("FAIL ovf_afull_%0d: got %b expected %b", n, wr_afull, (n >= 6));
            end
            tests++;
            if (wr_full !== (n >= 8)) begin
                fails++;
                $display("FAIL ovf_full_%0d: got %b expected %b", n, wr_full, (n >= 8));
            end
            tests++;
            if (wr_level !== 4'(n > 8 ? 8 : n)) begin
                fails++;
                $display("FAIL ovf_level_%0d: got %0d expected %0d", n, wr_level, (n > 8 ? 8 : n));
            end
        end
        wr_en = 1'b0;
        tests++;
        if (wr_ovf !== 1'b1) begin
            fails++;
            $display("FAIL ovf_set: got %b expected 1", wr_ovf);
        end
        wr_ovf_clr = 1'b1;
        wr_tick();
        wr_ovf_clr = 1'b0;
        tests++;
        if (wr_ovf !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear: got %b expected 0", wr_ovf);
        end
        repeat (4) rd_tick();
        tests++;
        if ({rd_level, rd_aempty} !== {4'd8, 1'b0}) begin
            fails++;
            $display("FAIL drain_start: level/aempty got %0d/%b expected 8/0", rd_level, rd_aempty);
        end
        for (int i = 1; i <= 8; i++) begin
            tests++;
            if ({rd_valid, rd_data} !== {1'b1, i[7:0]}) begin
                fails++;
                $display("FAIL drain_data_%0d: valid/data got %b/%h expected 1/%h", i, rd_valid, rd_data, i[7:0]);
            end
            tests++;
            if ({rd_level, rd_aempty} !== {4'(9 - i), ((9 - i) <= 2)}) begin
                fails++;
                $display("FAIL drain_level_%0d: level/aempty got %0d/%b expected %0d/%b",
                         i, rd_level, rd_aempty, 9 - i, ((9 - i) <= 2));
            end
            rd_en = 1'b1;
            rd_tick();
        end
        rd_en = 1'b0;
        tests++;
        if ({rd_valid, rd_unf, rd_level} !== {1'b0, 1'b0, 4'd0}) begin
            fails++;
            $display("FAIL drain_end: valid/unf/level got %b/%b/%0d expected 0/0/0", rd_valid, rd_unf, rd_level);
        end
        repeat (6) wr_tick();
    endtask

    task automatic test_underflow;
        rd_en = 1'b1;
        rd_tick();
        rd_en = 1'b0;
        tests++;
        if ({rd_unf, rd_level} !== {1'b1, 4'd0}) begin
            fails++;
            $display("FAIL unf_set: unf/level got %b/%0d expected 1/0", rd_unf, rd_level);
        end
        rd_en = 1'b1; rd_unf_clr = 1'b1;
        rd_tick();
        rd_en = 1'b0;
        tests++;
        if (rd_unf !== 1'b1) begin
            fails++;
            $display("FAIL unf_set_wins: got %b expected 1", rd_unf);
        end
        rd_tick();
        rd_unf_clr = 1'b0;
        tests++;
        if (rd_unf !== 1'b0) begin
            fails++;
            $display("FAIL unf_clear: got %b expected 0", rd_unf);
        end
    endtask

    task automatic test_random_stream;
        logic [7:0] exp_q[$];
        int got = 0;
        int data_err = 0;
        int lvl_err = 0;
        fork
            begin
                int sent = 0;
                int cyc = 0;
                while (sent < 1000 && cyc < 20000) begin
                    if (!wr_full && $urandom_range(0, 1) == 1) begin
                        wr_en = 1'b1;
                        wr_data = 8'($urandom);
                        exp_q.push_back(wr_data);
                        sent++;
                    end else begin
                        wr_en = 1'b0;
                    end
                    wr_tick();
                    cyc++;
                end
                wr_en = 1'b0;
            end
            begin
                int cyc = 0;
                while (got < 1000 && cyc < 30000) begin
                    if (wr_level < rd_level) lvl_err++;
                    if (rd_valid && $urandom_range(0, 1) == 1) begin
                        rd_en = 1'b1;
                        if (exp_q.size() == 0) data_err++;
                        else if (rd_data !== exp_q.pop_front()) data_err++;
                        got++;
                    end else begin
                        rd_en = 1'b0;
                    end
                    rd_tick();
                    cyc++;
                end
                rd_en = 1'b0;
            end
        join
        tests++;
        if (got !== 1000) begin
            fails++;
            $display("FAIL rand_count: got %0d words expected 1000", got);
        end
        tests++;
        if (data_err !== 0) begin
            fails++;
            $display("FAIL rand_data: got %0d mismatched words expected 0", data_err);
        end
        tests++;
        if (lvl_err !== 0) begin
            fails++;
            $display("FAIL rand_levels: got %0d samples with wr_level<rd_level expected 0", lvl_err);
        end
        tests++;
        if ({wr_ovf, rd_unf} !== 2'b00) begin
            fails++;
            $display("FAIL rand_flags: ovf/unf got %b/%b expected 0/0", wr_ovf, rd_unf);
        end
        repeat (6) wr_tick();
    endtask

    task automatic test_flush;
        logic found = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_data = 8'h50 + 8'(i); wr_en = 1'b1;
            wr_tick();
        end
        wr_en = 1'b0;
        repeat (4) rd_tick();
        tests++;
        if (rd_level !== 4'd5) begin
            fails++;
            $display("FAIL flush_pre_level: got %0d expected 5", rd_level);
        end
        wr_rst_n = 1'b0; rd_rst_n = 1'b0;
        #30;
        @(posedge wr_clk);
        #1;
        wr_rst_n = 1'b1; rd_rst_n = 1'b1;
        #1;
        tests++;
        if (status_vec() !== c_rst_vec) begin
            fails++;
            $display("FAIL flush_state: got %b expected %b", status_vec(), c_rst_vec);
        end
        wr_data = 8'h3C; wr_en = 1'b1;
        wr_tick();
        wr_en = 1'b0;
        for (int i = 0; i < 3 && !found; i++) begin
            rd_tick();
            if (rd_valid === 1'b1) found = 1'b1;
        end
        tests++;
        if ({found, rd_data, rd_level} !== {1'b1, 8'h3C, 4'd1}) begin
            fails++;
            $display("FAIL flush_first_word: valid/data/level got %b/%h/%0d expected 1/3c/1",
                     found, rd_data, rd_level);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_overflow();
        test_underflow();
        test_random_stream();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
